// File: rtl/zoom_pkg.sv
// rtl/zoom_pkg.sv - shared types and constants for the zoom add scheduler
// Contents: zoom_sched_state_e FSM encoding, default width and requester count.
package zoom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } zoom_sched_state_e;

  localparam int ZOOM_WIDTH   = 8;
  localparam int ZOOM_NUM_REQ = 4;

endpackage

// File: rtl/zoom_add_sched_if.sv
// rtl/zoom_add_sched_if.sv - requester and result handshake bundle
// Signals: req_valid/req_ready/req_a/req_b (per-requester operands, packed by index),
//          res_valid/res_ready/res_sum/res_carry/res_id (result stream).
// Modports: master = requester/consumer side, slave = scheduler side.
interface zoom_add_sched_if
  import zoom_pkg::*;
#(
  parameter int WIDTH   = ZOOM_WIDTH,
  parameter int NUM_REQ = ZOOM_NUM_REQ
) ();

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_sum;
  logic                     res_carry;
  logic [IDW-1:0]           res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_carry, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_carry, res_id
  );

endinterface

// File: rtl/zoom_rr_arbiter.sv
// rtl/zoom_rr_arbiter.sv - combinational round-robin picker
// Inputs:  req (request vector), ptr (last granted index), enable.
// Outputs: grant (one-hot), grant_idx (index of the grant), any_grant.
// Search starts at ptr+1 and wraps, so the last winner has lowest priority.
module zoom_rr_arbiter
  import zoom_pkg::*;
#(
  parameter int  NUM_REQ = ZOOM_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any_grant
);

  always_comb begin
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (enable && !any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zoom_add_sched.sv
// rtl/zoom_add_sched.sv - round-robin scheduler sharing one registered adder
// Ports: clk, rst (sync, active-high), en (grant enable), bus (slave side of
//        zoom_add_sched_if: operand requests in, result stream out), busy.
// Flow: grant -> EXEC (add into result regs) -> HOLD (until consumed).
module zoom_add_sched
  import zoom_pkg::*;
#(
  parameter int  WIDTH   = ZOOM_WIDTH,
  parameter int  NUM_REQ = ZOOM_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  zoom_add_sched_if.slave        bus,
  output logic                   busy
);

  zoom_sched_state_e state, state_nxt;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     op_id;
  logic [IDW-1:0]     grant_idx;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [NUM_REQ-1:0] grant;
  logic               accept_ok;
  logic               fire;

  // A new grant may overlap the cycle in which the held result is consumed.
  assign accept_ok = en & ((state == IDLE) | ((state == HOLD) & bus.res_ready));

  zoom_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .enable    (accept_ok),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (fire)
  );

  assign bus.req_ready = grant;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (bus.res_ready) state_nxt = fire ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= IDW'(NUM_REQ - 1);
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= '0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_carry <= 1'b0;
      bus.res_id    <= '0;
    end else begin
      if (fire) begin
        op_a   <= bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
        op_b   <= bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
        op_id  <= grant_idx;
        rr_ptr <= grant_idx;
      end
      if (state == EXEC) begin
        {bus.res_carry, bus.res_sum} <= {1'b0, op_a} + {1'b0, op_b};
        bus.res_id    <= op_id;
        bus.res_valid <= 1'b1;
      end else if ((state == HOLD) && bus.res_ready) begin
        // Drops even when a back-to-back grant fires; it returns after EXEC.
        bus.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/zoom_add_sched.md
Name: zoom_add_sched

Overview:
- Round-robin scheduler that shares one registered WIDTH-bit adder datapath among NUM_REQ requesters.
- Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, executes the add, and returns the sum, the carry and the requester id over a valid/ready result port with backpressure.
- Sits between the pin-facing input muxing and the top-level output register in the zoom_zoom design.

Parameters:
- WIDTH, 8, operand and sum width in bits
- NUM_REQ, 4, number of requesters (2..8)
- IDW, $clog2(NUM_REQ), width of the requester id (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  when low, no new grants are issued; an in-flight operation still completes
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit set
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B; same packing as req_a
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH
- res_carry  out  1  carry out of the add
- res_id  out  IDW  index of the requester that owns the result
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=NUM_REQ-1 (so requester 0 has first priority)
  - res_valid=0, res_sum=0, res_carry=0, res_id=0, busy=0
  - operand registers cleared
  - Any in-flight operation or held result is discarded with no response.
- FSM states: IDLE, EXEC, HOLD.
- Grant:
  - accept_ok = en & (state==IDLE | (state==HOLD & res_ready)).
  - When accept_ok is high and any req_valid is high, req_ready is one-hot for the first valid requester after rr_ptr, in increasing index order with wrap.
  - req_ready is combinational from req_valid, state, en, res_ready and rr_ptr; it is never high for a requester whose req_valid is low.
- Handshake fires on req_valid[i] & req_ready[i]. On that edge:
  - req_a/req_b slice i and id i are latched
  - rr_ptr <= i
  - state <= EXEC
- EXEC (one cycle):
  - {res_carry,res_sum} <= a+b computed at WIDTH+1 bits; res_id <= latched id; res_valid <= 1; state <= HOLD.
- HOLD:
  - res_valid=1. res_sum, res_carry and res_id stay stable until res_valid & res_ready.
  - On res_ready: if a new grant fires in the same cycle, state <= EXEC and res_valid stays 1 for that cycle only (it drops in EXEC). Otherwise state <= IDLE and res_valid <= 0.
- Timing:
  - Latency: handshake at cycle T gives res_valid=1 at cycle T+2.
  - Peak throughput is one operation per 2 cycles.
- Boundary conditions:
  - Wrap-around: a=2^WIDTH-1, b=1 gives sum=0, carry=1. No saturation.
  - en low in HOLD: result is still drained; return to IDLE only.
  - Requester dropping req_valid before it is granted: no effect and no state change.
  - Requester changing operands while not granted: no effect.
  - rst together with a handshake or res_ready: reset wins; nothing is latched.

Decomposition:
- Package zoom_pkg holds:
  - enum zoom_sched_state_e {IDLE, EXEC, HOLD}
  - constants ZOOM_WIDTH=8 and ZOOM_NUM_REQ=4
- Sub-module zoom_rr_arbiter (purely combinational):
  - inputs req, ptr, enable
  - outputs one-hot grant, grant index and any_grant
- The FSM, operand registers and adder stay in zoom_add_sched.

Test Plan:
- Reset then single request: req_valid=0001, a=0x12, b=0x34, res_ready=1 → req_ready=0001 at T; at T+2 res_valid=1, sum=0x46, carry=0, id=0; res_valid=0 at T+3.
- Overflow: a=0xFF, b=0x01 → sum=0x00, carry=1. a=0x80, b=0x80 → sum=0x00, carry=1.
- Fairness: all four req_valid held high, res_ready=1, 8 operations → grant order ids 0,1,2,3,0,1,2,3; one result every 2 cycles.
- Backpressure: result pending with res_ready=0 for 5 cycles → res_valid, sum and id constant; req_ready=0 throughout. Raising res_ready with req 2 valid → result consumed and req 2 granted in the same cycle.
- en gating: en=0 with requests pending → req_ready=0, busy=0 indefinitely. Drop en in EXEC → result still delivered, then no further grant.
- Mid-operation reset: rst=1 in EXEC → next cycle res_valid=0, busy=0; next grant goes to requester 0 when multiple requesters are valid.
